// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that grants one requester's entire message to a single UART TX byte stream.
// Optional feature: define ARB_TIMEOUT_EN to force release of an owner stalled for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      r_last_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [OW-1:0]      w_pick;
  logic               w_found;
  logic               w_xfer;
  logic               w_release_last;
  logic               w_expire;
  int                 w_idx;

  // The owner's byte stream is passed straight through; only ownership is registered.
  assign busy           = (r_state == S_BUSY);
  assign grant          = r_grant;
  assign tx_valid       = busy & req_valid[r_owner];
  assign tx_data        = busy ? req_data[{r_owner, 3'b000} +: 8] : 8'h00;
  assign req_ready      = busy ? (NUM_REQ'(tx_ready) << r_owner) : '0;
  assign w_xfer         = tx_valid & tx_ready;
  assign w_release_last = w_xfer & req_last[r_owner];

  // Search starts just after the previous owner so every requester gets its turn.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_owner) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = OW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_grant      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BUSY;
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
          end
        end
        S_BUSY: begin
          if (w_release_last || w_expire) begin
            r_state      <= S_IDLE;
            r_last_owner <= r_owner;
            r_grant      <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_timer;
  logic          r_timeout_err;

  // Expiry fires on the TIMEOUT-th consecutive owned cycle without a transfer.
  assign w_expire    = busy & ~w_xfer & (r_timer == TW'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_expire;
      if (!busy || w_xfer || w_expire) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign timeout_err      = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int NR = 3;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index (-1 = nobody), previous owner, stall count, pending error pulse.
  int   m_owner = -1;
  int   m_last  = NR - 1;
  int   m_cnt   = 0;
  logic m_err   = 1'b0;

  always @(negedge clk) begin
    logic          e_busy, e_txv;
    logic [NR-1:0] e_grant, e_rdy;
    if (!rst) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_cnt   = 0;
      m_err   = 1'b0;
    end
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? (NR'(1) << m_owner) : '0;
    e_txv   = e_busy ? req_valid[m_owner] : 1'b0;
    e_rdy   = (e_busy && tx_ready) ? (NR'(1) << m_owner) : '0;
    check("m_busy", busy, e_busy);
    check("m_grant", grant, e_grant);
    check("m_tx_valid", tx_valid, e_txv);
    check("m_req_ready", req_ready, e_rdy);
    check("m_timeout_err", timeout_err, m_err);
    if (e_busy) check("m_tx_data", tx_data, req_data[8*m_owner +: 8]);
    if (rst) begin
      m_err = 1'b0;
      if (!e_busy) begin
        for (int k = 1; k <= NR; k++)
          if (m_owner < 0 && req_valid[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
        m_cnt = 0;
      end else if (e_txv && tx_ready) begin
        m_cnt = 0;
        if (req_last[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else begin
`ifdef ARB_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin
          m_last  = m_owner;
          m_owner = -1;
          m_cnt   = 0;
          m_err   = 1'b1;
        end
`endif
      end
    end
  end

  // Autonomous requester traffic: holds a pending byte until accepted, random gaps and lengths.
  int            a_len [NR];
  int            a_idx [NR];
  logic [NR-1:0] acc;
  int            gq[$];

  task automatic auto_step(input int gap_pct, input int rdy_pct, input int fix_len);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        a_idx[i]++;
        if (a_idx[i] >= a_len[i]) begin
          a_idx[i] = 0;
          a_len[i] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
        end
        req_data[8*i +: 8] = 8'($urandom);
      end
      if (!(req_valid[i] && !acc[i])) req_valid[i] = (int'($urandom_range(0, 99)) >= gap_pct);
      req_last[i] = (a_idx[i] == a_len[i] - 1);
    end
    tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic run_auto(input int cycles, input int gap_pct, input int rdy_pct, input int fix_len);
    logic prev_busy;
    for (int i = 0; i < NR; i++) begin
      a_idx[i] = 0;
      a_len[i] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
    end
    acc       = '0;
    prev_busy = busy;
    gq.delete();
    for (int c = 0; c < cycles; c++) begin
      tick();
      auto_step(gap_pct, rdy_pct, fix_len);
      #2;
      if (busy && !prev_busy) gq.push_back(int'(grant));
      prev_busy = busy;
      acc = req_valid & req_ready;
    end
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Requester 1 sends "AB".
    req_valid = 3'b010;
    req_data[15:8] = 8'h41;
    #2 check("ab_idle_grant", grant, 0);
    tick(); #2;
    check("ab_grant", grant, 3'b010);
    check("ab_byte_a", tx_data, 8'h41);
    check("ab_req_ready", req_ready, 3'b010);
    tick();
    req_data[15:8] = 8'h42;
    req_last = 3'b010;
    #2 check("ab_byte_b", tx_data, 8'h42);
    check("ab_busy_b", busy, 1);
    tick();
    req_valid = '0;
    req_last  = '0;
    #2 check("ab_busy_fall", busy, 0);

    // Requesters 0 and 2 valid straight out of reset.
    tick();
    rst       = 1'b0;
    req_valid = 3'b101;
    req_data  = 24'h20_00_10;
    req_last  = 3'b101;
    tick(); tick();
    rst = 1'b1;
    #2 check("two_idle_grant", grant, 0);
    tick(); #2;
    check("two_first_grant", grant, 3'b001);
    check("two_first_data", tx_data, 8'h10);
    tick();
    req_valid[0] = 1'b0;
    #2 check("two_gap_grant", grant, 0);
    check("two_gap_tx_valid", tx_valid, 0);
    tick(); #2;
    check("two_second_grant", grant, 3'b100);
    check("two_second_data", tx_data, 8'h20);
    tick();
    req_valid = '0;
    req_last  = '0;
    #2 check("two_done_busy", busy, 0);

    // tx_ready stalls for 5 cycles during requester 0's single byte.
    tick();
    req_valid = 3'b001;
    req_data[7:0] = 8'h52;
    req_last = 3'b001;
    tx_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #2;
      check("stall_data", tx_data, 8'h52);
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
      tick();
    end
    tx_ready = 1'b1;
    #2 check("stall_release_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    req_last  = '0;
    #2 check("stall_done_busy", busy, 0);

    // Reset mid-message from requester 2.
    tick();
    req_valid = 3'b100;
    req_data[23:16] = 8'h30;
    tick();
    #2 check("mid_grant", grant, 3'b100);
    tick();
    req_data[23:16] = 8'h31;
    req_valid = 3'b101;
    req_data[7:0] = 8'h01;
    req_last = 3'b001;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_req_ready", req_ready, 0);
    tick();
    rst = 1'b1;
    #2 check("mid_after_tx_valid", tx_valid, 0);
    tick();
    #2 check("mid_regrant", grant, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    req_last = 3'b100;
    tick();
    #2 check("mid_req2_grant", grant, 3'b100);
    tick();
    req_valid = '0;
    req_last  = '0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Owner 0 stalls after one byte; forced release after TO idle cycles.
    do_reset();
    req_valid = 3'b011;
    req_data  = 24'h00_70_60;
    req_last  = 3'b010;
    tick();
    #2 check("to_grant", grant, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #2;
      check("to_held", busy, 1);
      check("to_no_err", timeout_err, 0);
      tick();
    end
    #2;
    check("to_released", busy, 0);
    check("to_err_pulse", timeout_err, 1);
    tick();
    #2;
    check("to_err_clear", timeout_err, 0);
    check("to_next_grant", grant, 3'b010);
    tick();
    req_valid = '0;
    req_last  = '0;
    tick();
`endif

    // Fairness: all requesters continuously sending 2-byte messages.
    do_reset();
    run_auto(30, 0, 100, 2);
    check("fair_count", (gq.size() >= 6), 1);
    for (int k = 0; k < 6; k++) begin
      if (k < gq.size()) check("fair_order", gq[k], 32'(1 << (k % 3)));
    end

    // Randomized traffic with gaps, back-pressure and variable message lengths.
    do_reset();
    run_auto(3000, 30, 70, 0);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
